hps_cmd_decoder: RTL



---
 rtl/hps_cmd_decoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hps_cmd_decoder.sv
// rtl/hps_cmd_decoder.sv - HPS SPI command framing decoder; define HPS_STATUS_RD_EN to enable status readback (0x29)
module hps_cmd_decoder #(
   parameter logic [15:0] CORE_ID    = 16'h0001,
   parameter logic [63:0] STATUS_RST = 64'h0
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        io_enable,
   input  logic        io_strobe,
   input  logic [15:0] io_din,
   output logic [15:0] io_dout,
   output logic [1:0]  buttons,
   output logic [7:0]  switches,
   output logic [31:0] joystick_0,
   output logic [31:0] joystick_1,
   output logic [63:0] status,
   output logic        status_upd,
   output logic        cmd_active
);

   localparam logic [7:0] CMD_BUTTONS = 8'h01;
   localparam logic [7:0] CMD_JOY0    = 8'h02;
   localparam logic [7:0] CMD_JOY1    = 8'h03;
   localparam logic [7:0] CMD_STATUS  = 8'h1E;
   localparam logic [7:0] CMD_IDENT   = 8'h32;
`ifdef HPS_STATUS_RD_EN
   localparam logic [7:0] CMD_STAT_RD = 8'h29;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_CMD,
      ST_CMD_DATA
   } state_t;

   state_t      state_q,    state_d;
   logic [7:0]  cmd_q,      cmd_d;
   logic [2:0]  widx_q,     widx_d;
   logic [15:0] js0_lo_q,   js0_lo_d;
   logic [15:0] js1_lo_q,   js1_lo_d;
   logic [47:0] stat_sh_q,  stat_sh_d;
   logic [15:0] dout_q,     dout_d;
   logic [1:0]  buttons_q,  buttons_d;
   logic [7:0]  switches_q, switches_d;
   logic [31:0] js0_q,      js0_d;
   logic [31:0] js1_q,      js1_d;
   logic [63:0] status_q,   status_d;
   logic        upd_q,      upd_d;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         widx_q     <= '0;
         js0_lo_q   <= '0;
         js1_lo_q   <= '0;
         stat_sh_q  <= '0;
         dout_q     <= '0;
         buttons_q  <= '0;
         switches_q <= '0;
         js0_q      <= '0;
         js1_q      <= '0;
         status_q   <= STATUS_RST;
         upd_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         widx_q     <= widx_d;
         js0_lo_q   <= js0_lo_d;
         js1_lo_q   <= js1_lo_d;
         stat_sh_q  <= stat_sh_d;
         dout_q     <= dout_d;
         buttons_q  <= buttons_d;
         switches_q <= switches_d;
         js0_q      <= js0_d;
         js1_q      <= js1_d;
         status_q   <= status_d;
         upd_q      <= upd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      widx_d     = widx_q;
      js0_lo_d   = js0_lo_q;
      js1_lo_d   = js1_lo_q;
      stat_sh_d  = stat_sh_q;
      dout_d     = dout_q;
      buttons_d  = buttons_q;
      switches_d = switches_q;
      js0_d      = js0_q;
      js1_d      = js1_q;
      status_d   = status_q;
      upd_d      = 1'b0;

      // Frame end takes priority over any strobe in the same cycle.
      if (!io_enable) begin
         state_d   = ST_IDLE;
         cmd_d     = '0;
         widx_d    = '0;
         js0_lo_d  = '0;
         js1_lo_d  = '0;
         stat_sh_d = '0;
         dout_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: begin
               if (io_strobe) begin
                  cmd_d   = io_din[7:0];
                  widx_d  = '0;
                  state_d = ST_CMD_DATA;
                  case (io_din[7:0])
                     CMD_IDENT:   dout_d = CORE_ID;
`ifdef HPS_STATUS_RD_EN
                     CMD_STAT_RD: dout_d = status_q[15:0];
`endif
                     default:     dout_d = '0;
                  endcase
               end
            end
            ST_CMD_DATA: begin
               // Index 7 is the saturation point; words there are dropped.
               if (io_strobe && (widx_q != 3'd7)) begin
                  widx_d = widx_q + 3'd1;
                  case (cmd_q)
                     CMD_BUTTONS: begin
                        if (widx_q == 3'd0) begin
                           buttons_d  = io_din[1:0];
                           switches_d = io_din[15:8];
                        end
                     end
                     CMD_JOY0: begin
                        if (widx_q == 3'd0) js0_lo_d = io_din;
                        if (widx_q == 3'd1) js0_d = {io_din, js0_lo_q};
                     end
                     CMD_JOY1: begin
                        if (widx_q == 3'd0) js1_lo_d = io_din;
                        if (widx_q == 3'd1) js1_d = {io_din, js1_lo_q};
                     end
                     CMD_STATUS: begin
                        case (widx_q)
                           3'd0: stat_sh_d[15:0]  = io_din;
                           3'd1: stat_sh_d[31:16] = io_din;
                           3'd2: stat_sh_d[47:32] = io_din;
                           3'd3: begin
                              status_d = {io_din, stat_sh_q};
                              upd_d    = 1'b1;
                           end
                           default: ;
                        endcase
                     end
`ifdef HPS_STATUS_RD_EN
                     CMD_STAT_RD: begin
                        case (widx_q)
                           3'd0:    dout_d = status_q[31:16];
                           3'd1:    dout_d = status_q[47:32];
                           3'd2:    dout_d = status_q[63:48];
                           default: dout_d = '0;
                        endcase
                     end
`endif
                     default: ;
                  endcase
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign io_dout    = dout_q;
   assign buttons    = buttons_q;
   assign switches   = switches_q;
   assign joystick_0 = js0_q;
   assign joystick_1 = js1_q;
   assign status     = status_q;
   assign status_upd = upd_q;
   assign cmd_active = (state_q == ST_CMD_DATA);

endmodule
